// File: rtl/pipeline_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_unit_pkg
// Shared definitions for the pipeline sequencer: default widths, the encoding
// of the run mode sampled at start, and the sequencer state encoding.
// No ports; imported by pipeline_ctrl_unit and hazard_detect.
// ---------------------------------------------------------------------------
package pipeline_ctrl_unit_pkg;

  localparam int NB_PC     = 7;
  localparam int NB_REG    = 5;
  localparam int NB_CYCLES = 32;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    HALTED    = 3'd4
  } ctrlState_e;

  // Only RUN and the single STEP_EXEC cycle are allowed to move the pipeline;
  // every other state keeps the inter-stage registers frozen.
  function automatic logic isAdvancingState(ctrlState_e state);
    return (state == RUN) || (state == STEP_EXEC);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use detector. Flags the case where the load now
// in execute writes a register that the instruction in decode reads.
// Ports:
//   exMemRead_i : instruction in execute is a load
//   exRt_i      : destination register of that load
//   idRs_i      : rs of the instruction in decode
//   idRt_i      : rt of the instruction in decode
//   loadUse_o   : decode must wait one cycle for the load data
// ---------------------------------------------------------------------------
module hazard_detect
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int NB_REG = pipeline_ctrl_unit_pkg::NB_REG
) (
  input  logic              exMemRead_i,
  input  logic [NB_REG-1:0] exRt_i,
  input  logic [NB_REG-1:0] idRs_i,
  input  logic [NB_REG-1:0] idRt_i,
  output logic              loadUse_o
);

  // Register zero is hardwired, so a load targeting it never creates a
  // real dependency and must not cost a stall cycle.
  always_comb begin
    loadUse_o = exMemRead_i
              && (exRt_i != '0)
              && ((exRt_i == idRs_i) || (exRt_i == idRt_i));
  end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_unit
// Central sequencer for the 5-stage MIPS pipeline. Runs the pipeline either
// continuously or one cycle per step pulse, stops for good on HALT, inserts
// load-use stalls, flushes IF/ID on taken branches and counts advanced cycles.
// Ports:
//   clock_i, reset_i        : clock, synchronous active-low reset
//   start_i, mode_i         : start pulse; mode (0 run, 1 step) sampled with it
//   step_i                  : advance one cycle while in step mode
//   halt_detected_i         : HALT present in writeback
//   id_rs_i, id_rt_i        : source registers of the decode instruction
//   ex_mem_read_i, ex_rt_i  : load in execute and its destination register
//   branch_taken_i          : branch/jump resolved taken
//   en_pipeline_o           : global inter-stage register enable
//   pc_write_o, if_id_en_o  : PC and IF/ID enables (dropped during a stall)
//   if_id_flush_o           : load a NOP into IF/ID
//   id_ex_bubble_o          : load NOP controls into ID/EX
//   running_o, halted_o     : status flags
//   cycle_count_o           : saturating count of advanced cycles
// ---------------------------------------------------------------------------
module pipeline_ctrl_unit
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int NB_REG    = pipeline_ctrl_unit_pkg::NB_REG,
  parameter int NB_CYCLES = pipeline_ctrl_unit_pkg::NB_CYCLES
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic                 step_i,
  input  logic                 halt_detected_i,
  input  logic [NB_REG-1:0]    id_rs_i,
  input  logic [NB_REG-1:0]    id_rt_i,
  input  logic                 ex_mem_read_i,
  input  logic [NB_REG-1:0]    ex_rt_i,
  input  logic                 branch_taken_i,
  output logic                 en_pipeline_o,
  output logic                 pc_write_o,
  output logic                 if_id_en_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_bubble_o,
  output logic                 running_o,
  output logic                 halted_o,
  output logic [NB_CYCLES-1:0] cycle_count_o
);

  ctrlState_e           state_q;
  ctrlState_e           state_d;
  logic [NB_CYCLES-1:0] cycleCount_q;
  logic [NB_CYCLES-1:0] cycleCount_d;
  logic                 loadUse;
  logic                 advance;
  logic                 stall;

  hazard_detect #(
    .NB_REG (NB_REG)
  ) uHazardDetect (
    .exMemRead_i (ex_mem_read_i),
    .exRt_i      (ex_rt_i),
    .idRs_i      (id_rs_i),
    .idRt_i      (id_rt_i),
    .loadUse_o   (loadUse)
  );

  // The pipeline moves only in an advancing state, and never in the cycle the
  // HALT reaches writeback. A taken branch already discards the younger
  // instruction, so it takes precedence over the load-use stall.
  always_comb begin
    advance        = isAdvancingState(state_q) && !halt_detected_i;
    stall          = advance && loadUse && !branch_taken_i;
    en_pipeline_o  = advance;
    pc_write_o     = advance && !stall;
    if_id_en_o     = advance && !stall;
    if_id_flush_o  = advance && branch_taken_i;
    id_ex_bubble_o = stall;
    running_o      = (state_q == RUN) || (state_q == STEP_WAIT) || (state_q == STEP_EXEC);
    halted_o       = (state_q == HALTED);
    cycle_count_o  = cycleCount_q;
  end

  // Sequencer next state. The run mode lives only in which state we enter
  // from IDLE, so later mode_i changes cannot affect a running program.
  // HALT beats a simultaneous step, and STEP_EXEC always lasts exactly one
  // cycle regardless of step_i. HALTED is left only through reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (mode_i == MODE_STEP) ? STEP_WAIT : RUN;
        end
      end
      RUN: begin
        if (halt_detected_i) begin
          state_d = HALTED;
        end
      end
      STEP_WAIT: begin
        if (halt_detected_i) begin
          state_d = HALTED;
        end else if (step_i) begin
          state_d = STEP_EXEC;
        end
      end
      STEP_EXEC: begin
        state_d = halt_detected_i ? HALTED : STEP_WAIT;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Cycle counter: cleared when a new program starts, then bumped on every
  // advancing cycle (stalls included) and held at all-ones once saturated.
  always_comb begin
    cycleCount_d = cycleCount_q;
    if ((state_q == IDLE) && start_i) begin
      cycleCount_d = '0;
    end else if (advance && (cycleCount_q != '1)) begin
      cycleCount_d = cycleCount_q + 1'b1;
    end
  end

  // State and counter registers with synchronous active-low reset; a reset in
  // the middle of a run or a pending step simply drops everything back to IDLE.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      cycleCount_q <= '0;
    end else begin
      state_q      <= state_d;
      cycleCount_q <= cycleCount_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl_unit
// Drives two copies of the sequencer (32-bit and 4-bit cycle counters) with
// identical stimulus, predicts every cycle's outputs from a behavioural model
// and checks them through a scoreboard queue popped by a separate monitor.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl_unit;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        step = 1'b0;
  logic        halt = 1'b0;
  logic        memRead = 1'b0;
  logic        branchTaken = 1'b0;
  logic [4:0]  idRs = '0;
  logic [4:0]  idRt = '0;
  logic [4:0]  exRt = '0;

  logic        enA, pcWriteA, ifIdEnA, flushA, bubbleA, runningA, haltedA;
  logic [31:0] countA;
  logic        enB, pcWriteB, ifIdEnB, flushB, bubbleB, runningB, haltedB;
  logic [3:0]  countB;

  typedef struct {
    logic [4:0]  enables;
    logic [1:0]  status;
    logic [31:0] count32;
    logic [3:0]  count4;
    int          cycle;
  } expect_t;

  expect_t sbQueue[$];
  expect_t monExp;
  int      compared = 0;
  int      mismatched = 0;
  int      stimCycle = 0;

  // Reference model: a program is either not started, active (continuous or
  // stepping) or halted; a step grants exactly the following cycle.
  bit      mKnown = 1'b0;
  bit      mActive = 1'b0;
  bit      mStepMode = 1'b0;
  bit      mStepGrant = 1'b0;
  bit      mHalted = 1'b0;
  longint  mCount = 0;

  always #5 clock = ~clock;

  pipeline_ctrl_unit #(
    .NB_REG    (5),
    .NB_CYCLES (32)
  ) dutWide (
    .clock_i         (clock),
    .reset_i         (resetN),
    .start_i         (start),
    .mode_i          (mode),
    .step_i          (step),
    .halt_detected_i (halt),
    .id_rs_i         (idRs),
    .id_rt_i         (idRt),
    .ex_mem_read_i   (memRead),
    .ex_rt_i         (exRt),
    .branch_taken_i  (branchTaken),
    .en_pipeline_o   (enA),
    .pc_write_o      (pcWriteA),
    .if_id_en_o      (ifIdEnA),
    .if_id_flush_o   (flushA),
    .id_ex_bubble_o  (bubbleA),
    .running_o       (runningA),
    .halted_o        (haltedA),
    .cycle_count_o   (countA)
  );

  pipeline_ctrl_unit #(
    .NB_REG    (5),
    .NB_CYCLES (4)
  ) dutNarrow (
    .clock_i         (clock),
    .reset_i         (resetN),
    .start_i         (start),
    .mode_i          (mode),
    .step_i          (step),
    .halt_detected_i (halt),
    .id_rs_i         (idRs),
    .id_rt_i         (idRt),
    .ex_mem_read_i   (memRead),
    .ex_rt_i         (exRt),
    .branch_taken_i  (branchTaken),
    .en_pipeline_o   (enB),
    .pc_write_o      (pcWriteB),
    .if_id_en_o      (ifIdEnB),
    .if_id_flush_o   (flushB),
    .id_ex_bubble_o  (bubbleB),
    .running_o       (runningB),
    .halted_o        (haltedB),
    .cycle_count_o   (countB)
  );

  // One stimulus cycle: drive inputs just after the rising edge, push the
  // model's prediction for this cycle, then step the model past the next edge.
  task automatic applyStimulus(input logic r, input logic s, input logic m,
                               input logic st, input logic h, input logic rd,
                               input logic br, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] ert);
    expect_t e;
    bit      adv;
    bit      lu;
    bit      stallE;
    @(posedge clock);
    #1;
    resetN = r; start = s; mode = m; step = st; halt = h;
    memRead = rd; branchTaken = br; idRs = rs; idRt = rt; exRt = ert;
    stimCycle++;
    adv = 1'b0;
    if (mKnown) begin
      adv    = mActive && (!mStepMode || mStepGrant) && !h;
      lu     = rd && (ert != 5'd0) && ((ert == rs) || (ert == rt));
      stallE = adv && lu && !br;
      e.enables = {adv, adv && !stallE, adv && !stallE, adv && br, stallE};
      e.status  = {mActive, mHalted};
      e.count32 = (mCount > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(mCount);
      e.count4  = (mCount > 15) ? 4'hF : 4'(mCount);
      e.cycle   = stimCycle;
      sbQueue.push_back(e);
    end
    if (!r) begin
      mKnown = 1'b1; mActive = 1'b0; mStepMode = 1'b0;
      mStepGrant = 1'b0; mHalted = 1'b0; mCount = 0;
    end else if (mKnown) begin
      if (adv) mCount++;
      if (mHalted) begin
        mHalted = 1'b1;
      end else if (mActive) begin
        if (h) begin
          mHalted = 1'b1; mActive = 1'b0; mStepGrant = 1'b0;
        end else if (mStepMode) begin
          mStepGrant = mStepGrant ? 1'b0 : st;
        end
      end else if (s) begin
        mActive = 1'b1; mStepMode = m; mStepGrant = 1'b0; mCount = 0;
      end
    end
  endtask

  task automatic runQuiet(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  task automatic compareField(input string name, input logic [31:0] actual,
                              input logic [31:0] expected, input int cyc);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    compareField("enablesWide", 32'({enA, pcWriteA, ifIdEnA, flushA, bubbleA}), 32'(e.enables), e.cycle);
    compareField("enablesNarrow", 32'({enB, pcWriteB, ifIdEnB, flushB, bubbleB}), 32'(e.enables), e.cycle);
    compareField("status", 32'({runningA, haltedA, runningB, haltedB}), 32'({e.status, e.status}), e.cycle);
    compareField("count32", countA, e.count32, e.cycle);
    compareField("count4", 32'(countB), 32'(e.count4), e.cycle);
  endtask

  // Monitor: outputs are presented every cycle, so pop one prediction at each
  // falling edge, well away from the rising edge where inputs change.
  always @(negedge clock) begin
    if (sbQueue.size() > 0) begin
      monExp = sbQueue.pop_front();
      checkOutput(monExp);
    end
  end

  // Hard stop in case the stimulus process ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    runQuiet(1);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    runQuiet(10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    runQuiet(2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    runQuiet(2);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      runQuiet(3);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    end
    runQuiet(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    runQuiet(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    runQuiet(2);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 5'd3, 5'd8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 5'd8, 5'd8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 5'd3, 5'd8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd3, 5'd8);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    runQuiet(5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    runQuiet(2);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    runQuiet(20);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    runQuiet(1);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 99) >= 2), 1'($urandom_range(0, 9) == 0),
                    1'($urandom), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 39) == 0), 1'($urandom),
                    1'($urandom_range(0, 4) == 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)));
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    runQuiet(1);
    repeat (3) @(negedge clock);
    #1;
    if (sbQueue.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending predictions, expected 0", sbQueue.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
